// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare direction predictor.
//   - ctr_e      : 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - GHR_BIT_DEFAULT : default global-history length
//   - sat_update : next value of a 2-bit counter given a resolved outcome
package gshare_predictor_pkg;

  localparam int GHR_BIT_DEFAULT = 5;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/gshare_predictor_pht.sv
// pattern_history_table: 2^IDX_W entries of 2-bit saturating counters.
// Ports:
//   clk, reset        : clock, synchronous active-low reset (all entries -> INIT_COUNTER)
//   rd_idx / rd_taken : combinational read port, returns MSB of the addressed counter
//   wr_en, wr_idx,
//   wr_taken          : synchronous training port; counter saturates at SNT/ST
// A read of the entry being trained in the same cycle returns the old value.
module pattern_history_table
  import gshare_predictor_pkg::*;
#(
  parameter int         IDX_W        = GHR_BIT_DEFAULT,
  parameter logic [1:0] INIT_COUNTER = WNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] pht_q [DEPTH];
  logic [1:0] pht_d [DEPTH];

  assign rd_taken = pht_q[rd_idx][1];

  always_comb begin
    pht_d = pht_q;
    if (wr_en) pht_d[wr_idx] = sat_update(pht_q[wr_idx], wr_taken);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) pht_q[i] <= INIT_COUNTER;
    end else begin
      pht_q <= pht_d;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: IF-stage global-history direction predictor.
// Ports:
//   clk, reset                      : clock, synchronous active-low reset
//   current_pc, fetch_advance,
//   fetch_is_branch                 : fetch-side inputs
//   pred_taken, pred_ghr            : same-cycle prediction and the history it used
//   ID_EX_pc, ID_EX_ghr,
//   ID_EX_is_branch, EX_alu_bcond   : EX-resolved branch for training/recovery
//   is_flush                        : EX redirect, restores speculative history
//   branch_count, mispredict_count  : saturating performance counters
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int         GHR_BIT      = GHR_BIT_DEFAULT,
  parameter logic [1:0] INIT_COUNTER = WNT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        current_pc,
  input  logic               fetch_advance,
  input  logic               fetch_is_branch,
  output logic               pred_taken,
  output logic [GHR_BIT-1:0] pred_ghr,
  input  logic [31:0]        ID_EX_pc,
  input  logic [GHR_BIT-1:0] ID_EX_ghr,
  input  logic               ID_EX_is_branch,
  input  logic               EX_alu_bcond,
  input  logic               is_flush,
  output logic [31:0]        branch_count,
  output logic [31:0]        mispredict_count
);

  logic [GHR_BIT-1:0] spec_ghr_q, spec_ghr_d;
  logic [31:0]        branch_count_q, branch_count_d;
  logic [31:0]        mispredict_count_q, mispredict_count_d;
  logic [GHR_BIT-1:0] idx_f, idx_e;

  assign idx_f = current_pc[GHR_BIT+1:2] ^ spec_ghr_q;
  assign idx_e = ID_EX_pc[GHR_BIT+1:2] ^ ID_EX_ghr;

  pattern_history_table #(
    .IDX_W        (GHR_BIT),
    .INIT_COUNTER (INIT_COUNTER)
  ) u_pht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx_f),
    .rd_taken (pred_taken),
    .wr_en    (ID_EX_is_branch),
    .wr_idx   (idx_e),
    .wr_taken (EX_alu_bcond)
  );

  assign pred_ghr         = spec_ghr_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

  always_comb begin
    spec_ghr_d         = spec_ghr_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;

    // A flush squashes the fetched instruction, so recovery always wins over
    // the speculative fetch-side shift.
    if (is_flush && ID_EX_is_branch) begin
      spec_ghr_d = {ID_EX_ghr[GHR_BIT-2:0], EX_alu_bcond};
    end else if (is_flush) begin
      spec_ghr_d = ID_EX_ghr;
    end else if (fetch_advance && fetch_is_branch) begin
      spec_ghr_d = {spec_ghr_q[GHR_BIT-2:0], pred_taken};
    end

    if (ID_EX_is_branch && (branch_count_q != 32'hFFFF_FFFF))
      branch_count_d = branch_count_q + 32'd1;
    if (ID_EX_is_branch && is_flush && (mispredict_count_q != 32'hFFFF_FFFF))
      mispredict_count_d = mispredict_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      spec_ghr_q         <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      spec_ghr_q         <= spec_ghr_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] current_pc;
  logic        fetch_advance;
  logic        fetch_is_branch;
  logic        pred_taken;
  logic [4:0]  pred_ghr;
  logic [31:0] ID_EX_pc;
  logic [4:0]  ID_EX_ghr;
  logic        ID_EX_is_branch;
  logic        EX_alu_bcond;
  logic        is_flush;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  gshare_predictor #(.GHR_BIT(5), .INIT_COUNTER(2'b01)) dut (
    .clk              (clk),
    .reset            (reset),
    .current_pc       (current_pc),
    .fetch_advance    (fetch_advance),
    .fetch_is_branch  (fetch_is_branch),
    .pred_taken       (pred_taken),
    .pred_ghr         (pred_ghr),
    .ID_EX_pc         (ID_EX_pc),
    .ID_EX_ghr        (ID_EX_ghr),
    .ID_EX_is_branch  (ID_EX_is_branch),
    .EX_alu_bcond     (EX_alu_bcond),
    .is_flush         (is_flush),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pt;
    logic [4:0]  pg;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: counters as plain integers, history as an integer.
  int     m_pht [32];
  int     m_ghr;
  longint m_bc, m_mc;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_pht[i] = 1;
    m_ghr = 0;
    m_bc  = 0;
    m_mc  = 0;
  endfunction

  // One clock cycle: drive inputs, record the expected same-cycle outputs,
  // then advance the model across the coming edge.
  task automatic cyc(input int pc, input int adv, input int fb, input int epc,
                     input int eghr, input int ebr, input int bcond, input int flush,
                     input int rst_n);
    exp_t e;
    int   fi, ei, pt;
    current_pc      = pc;
    fetch_advance   = (adv != 0);
    fetch_is_branch = (fb != 0);
    ID_EX_pc        = epc;
    ID_EX_ghr       = eghr[4:0];
    ID_EX_is_branch = (ebr != 0);
    EX_alu_bcond    = (bcond != 0);
    is_flush        = (flush != 0);
    reset           = (rst_n != 0);

    fi   = ((pc >>> 2) ^ m_ghr) & 31;
    pt   = (m_pht[fi] >= 2) ? 1 : 0;
    e.pt = pt[0];
    e.pg = m_ghr[4:0];
    e.bc = m_bc[31:0];
    e.mc = m_mc[31:0];
    q.push_back(e);

    if (rst_n == 0) begin
      model_reset();
    end else begin
      if (ebr != 0) begin
        ei = ((epc >>> 2) ^ eghr) & 31;
        if (bcond != 0) m_pht[ei] = (m_pht[ei] == 3) ? 3 : m_pht[ei] + 1;
        else            m_pht[ei] = (m_pht[ei] == 0) ? 0 : m_pht[ei] - 1;
        if (m_bc < 64'hFFFF_FFFF) m_bc++;
        if (flush != 0 && m_mc < 64'hFFFF_FFFF) m_mc++;
      end
      if (flush != 0 && ebr != 0)      m_ghr = ((eghr << 1) | (bcond != 0 ? 1 : 0)) & 31;
      else if (flush != 0)             m_ghr = eghr & 31;
      else if (adv != 0 && fb != 0)    m_ghr = ((m_ghr << 1) | pt) & 31;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int pc);
    cyc(pc, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: outputs are combinational, so each cycle's response is sampled
  // at the falling edge and compared against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (pred_taken !== e.pt) begin
        bad++;
        $display("FAIL pred_taken t=%0t got=%0b want=%0b", $time, pred_taken, e.pt);
      end
      total++;
      if (pred_ghr !== e.pg) begin
        bad++;
        $display("FAIL pred_ghr t=%0t got=%05b want=%05b", $time, pred_ghr, e.pg);
      end
      total++;
      if (branch_count !== e.bc) begin
        bad++;
        $display("FAIL branch_count t=%0t got=%0d want=%0d", $time, branch_count, e.bc);
      end
      total++;
      if (mispredict_count !== e.mc) begin
        bad++;
        $display("FAIL mispredict_count t=%0t got=%0d want=%0d", $time, mispredict_count, e.mc);
      end
    end
  end

  initial begin
    int wait_cnt;
    current_pc = 0; fetch_advance = 0; fetch_is_branch = 0;
    ID_EX_pc = 0; ID_EX_ghr = 0; ID_EX_is_branch = 0; EX_alu_bcond = 0; is_flush = 0;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset state
    idle(32'h40);

    // Training: two taken updates on pht[0x10], then read it back
    cyc(32'h40, 0, 0, 32'h40, 0, 1, 1, 0, 1);
    cyc(32'h40, 0, 0, 32'h40, 0, 1, 1, 0, 1);
    idle(32'h40);

    // Saturation high then low, reading the same entry each cycle
    for (int i = 0; i < 3; i++) cyc(32'h40, 0, 0, 32'h40, 0, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++) cyc(32'h40, 0, 0, 32'h40, 0, 1, 0, 0, 1);
    idle(32'h40);

    // Speculative shift: make pht[0x10] taken, then shift, then hold
    cyc(32'h40, 0, 0, 32'h40, 0, 1, 1, 0, 1);
    cyc(32'h40, 0, 0, 32'h40, 0, 1, 1, 0, 1);
    cyc(32'h40, 1, 1, 0, 0, 0, 0, 0, 1);
    cyc(32'h40, 0, 1, 0, 0, 0, 0, 0, 1);
    idle(32'h40);

    // Recovery: branch flush beats fetch shift, then jal flush
    cyc(32'h40, 1, 1, 32'h80, 5'b10110, 1, 0, 1, 1);
    idle(32'h40);
    cyc(32'h40, 1, 1, 32'h80, 5'b00111, 0, 0, 1, 1);
    idle(32'h40);

    // Randomized traffic with occasional mid-run resets
    for (int n = 0; n < 400; n++) begin
      cyc($urandom, $urandom_range(0, 1), $urandom_range(0, 1), $urandom,
          $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 7) == 0) ? 1 : 0,
          ($urandom_range(0, 79) == 0) ? 0 : 1);
    end

    // Mid-operation reset coinciding with a train and a fetch shift
    for (int i = 0; i < 4; i++) cyc(32'h40, 0, 0, 32'h40, 0, 1, 1, 0, 1);
    cyc(32'h40, 1, 1, 32'h40, 0, 1, 1, 0, 0);
    idle(32'h40);
    // Every entry must be back at weakly-not-taken: one taken step flips it
    for (int i = 0; i < 32; i++) cyc(i << 2, 0, 0, i << 2, 0, 1, 1, 0, 1);
    for (int i = 0; i < 32; i++) idle(i << 2);

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
